// File: rtl/uart_pkg.sv
// Shared UART-side definitions: parser state encoding, frame constants and small helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         CLK_HZ            = 40_000_000;

  // Frame checksum: modulo-256 sum of address and data bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
    return addr + data;
  endfunction

  // 8-bit increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_deframer.sv
// Command frame parser fed by the UART receiver: pops bytes, parses SYNC/ADDR/DATA/CHK
// frames, strobes register writes and keeps good/bad frame counters.
module uart_cmd_deframer
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 40000,
  parameter int         TO_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        uld_rx_data,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        chk_err,
  output logic        to_err,
  output logic [15:0] good_cnt,
  output logic [7:0]  bad_cnt
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic             wait_empty_q, wait_empty_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             uld_q, uld_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             chk_err_q, chk_err_d;
  logic             to_err_q, to_err_d;
  logic [15:0]      good_q, good_d;
  logic [7:0]       bad_q, bad_d;
  logic             pop_s;

  // The receiver's rx_empty lags our pop by a cycle, so wait_empty blocks re-reading
  // the same byte until rx_empty has been seen high.
  assign pop_s = enable & ~rx_empty & ~wait_empty_q;

  // Next-state logic: pop handshake, frame FSM (byte handled the cycle after its pop),
  // inter-byte timeout and counters.
  always_comb begin
    state_d      = state_q;
    wait_empty_d = wait_empty_q;
    to_cnt_d     = to_cnt_q;
    byte_d       = byte_q;
    uld_d        = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    chk_err_d    = 1'b0;
    to_err_d     = 1'b0;
    good_d       = good_q;
    bad_d        = bad_q;

    if (!enable) begin
      state_d      = ST_IDLE;
      wait_empty_d = 1'b0;
      to_cnt_d     = '0;
    end else begin
      if (pop_s) begin
        uld_d        = 1'b1;
        byte_d       = rx_data;
        wait_empty_d = 1'b1;
      end else if (rx_empty) begin
        wait_empty_d = 1'b0;
      end else begin
        wait_empty_d = wait_empty_q;
      end

      case (state_q)
        ST_IDLE: begin
          to_cnt_d = '0;
          if (uld_q && (byte_q == SYNC_BYTE)) begin
            state_d = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ADDR, ST_DATA, ST_CHK: begin
          if (uld_q) begin
            case (state_q)
              ST_ADDR: begin
                addr_d  = byte_q;
                state_d = ST_DATA;
              end
              ST_DATA: begin
                data_d  = byte_q;
                state_d = ST_CHK;
              end
              ST_CHK: begin
                if (byte_q == frame_chk(addr_q, data_q)) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = data_q;
                  good_d    = good_q + 16'd1;
                end else begin
                  chk_err_d = 1'b1;
                  bad_d     = sat_inc8(bad_q);
                end
                state_d = ST_IDLE;
              end
              default: state_d = ST_IDLE;
            endcase
          end
          // A pop in the same cycle as expiry keeps the frame alive.
          if (pop_s) begin
            to_cnt_d = '0;
          end else if (!uld_q && (to_cnt_q == TO_LAST)) begin
            to_err_d = 1'b1;
            bad_d    = sat_inc8(bad_q);
            state_d  = ST_IDLE;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_empty_q <= 1'b0;
      to_cnt_q     <= '0;
      byte_q       <= 8'h00;
      uld_q        <= 1'b0;
      addr_q       <= 8'h00;
      data_q       <= 8'h00;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 8'h00;
      wr_data_q    <= 8'h00;
      chk_err_q    <= 1'b0;
      to_err_q     <= 1'b0;
      good_q       <= 16'h0000;
      bad_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      wait_empty_q <= wait_empty_d;
      to_cnt_q     <= to_cnt_d;
      byte_q       <= byte_d;
      uld_q        <= uld_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      chk_err_q    <= chk_err_d;
      to_err_q     <= to_err_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
    end
  end

  assign uld_rx_data = uld_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign chk_err     = chk_err_q;
  assign to_err      = to_err_q;
  assign good_cnt    = good_q;
  assign bad_cnt     = bad_q;

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Directed bench for uart_cmd_deframer with a simple receiver-side byte driver.
module tb_uart_cmd_deframer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        uld_rx_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        chk_err;
  logic        to_err;
  logic [15:0] good_cnt;
  logic [7:0]  bad_cnt;

  int checks = 0;
  int errors = 0;

  uart_cmd_deframer dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .uld_rx_data (uld_rx_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .chk_err     (chk_err),
    .to_err      (to_err),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge.
  int n_uld = 0, n_wr = 0, n_chk = 0, n_to = 0, n_excl = 0, wr_cyc = 0;
  always @(negedge clk) begin
    if (uld_rx_data) n_uld <= n_uld + 1;
    if (wr_en) begin
      n_wr   <= n_wr + 1;
      wr_cyc <= cyc;
    end
    if (chk_err) n_chk <= n_chk + 1;
    if (to_err) n_to <= n_to + 1;
    if ((32'(wr_en) + 32'(chk_err) + 32'(to_err)) > 32'd1) n_excl <= n_excl + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int rx_cyc = 0;

  // Present one byte, wait for its pop, keep rx_empty low for the receiver's one-cycle
  // lag plus 'hold' extra cycles, then go empty for gap+1 cycles.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    bit got;
    got      = 1'b0;
    rx_data  = b;
    rx_empty = 1'b0;
    rx_cyc   = cyc;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (uld_rx_data) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("pop_seen", 32'(got), 32'd1);
    tick(1 + hold);
    rx_empty = 1'b1;
    tick(gap + 1);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                            input int hold, input int gap);
    send_byte(8'hA5, hold, gap);
    send_byte(a, hold, gap);
    send_byte(d, hold, gap);
    send_byte(c, hold, gap);
  endtask

  int wr0, chk0, to0, uld0;

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    check_eq("rst_uld", 32'(uld_rx_data), 32'd0);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    check_eq("rst_good", 32'(good_cnt), 32'd0);
    check_eq("rst_bad", 32'(bad_cnt), 32'd0);

    // 1: widely spaced valid frame, with write latency
    wr0 = n_wr;
    send_byte(8'hA5, 0, 400);
    send_byte(8'h10, 0, 400);
    send_byte(8'h22, 0, 400);
    send_byte(8'h32, 0, 0);
    tick(2);
    check_eq("t1_wr_cnt", 32'(n_wr - wr0), 32'd1);
    check_eq("t1_latency", 32'(wr_cyc - rx_cyc), 32'd2);
    check_eq("t1_addr", 32'(wr_addr), 32'h10);
    check_eq("t1_data", 32'(wr_data), 32'h22);
    check_eq("t1_good", 32'(good_cnt), 32'd1);

    // 2: checksum error
    wr0 = n_wr; chk0 = n_chk;
    send_frame(8'h10, 8'h22, 8'h33, 0, 3);
    tick(2);
    check_eq("t2_chk_err", 32'(n_chk - chk0), 32'd1);
    check_eq("t2_no_wr", 32'(n_wr - wr0), 32'd0);
    check_eq("t2_bad", 32'(bad_cnt), 32'd1);

    // 3: leading junk ignored
    wr0 = n_wr; chk0 = n_chk;
    send_byte(8'h00, 0, 2);
    send_byte(8'hFF, 0, 2);
    send_frame(8'h01, 8'h02, 8'h03, 0, 2);
    tick(2);
    check_eq("t3_wr_cnt", 32'(n_wr - wr0), 32'd1);
    check_eq("t3_addr", 32'(wr_addr), 32'h01);
    check_eq("t3_data", 32'(wr_data), 32'h02);
    check_eq("t3_no_err", 32'(n_chk - chk0), 32'd0);
    check_eq("t3_good", 32'(good_cnt), 32'd2);

    // 4: inter-byte timeout
    to0 = n_to;
    send_byte(8'hA5, 0, 1);
    send_byte(8'h10, 0, 1);
    tick(39990);
    check_eq("t4_not_early", 32'(n_to - to0), 32'd0);
    tick(1000);
    check_eq("t4_to_once", 32'(n_to - to0), 32'd1);
    check_eq("t4_bad", 32'(bad_cnt), 32'd2);
    wr0 = n_wr;
    send_byte(8'h10, 0, 2);
    send_byte(8'h22, 0, 2);
    send_byte(8'h32, 0, 2);
    tick(2);
    check_eq("t4_idle_after_to", 32'(n_wr - wr0), 32'd0);
    send_frame(8'h20, 8'h30, 8'h50, 0, 2);
    tick(2);
    check_eq("t4_next_frame", 32'(n_wr - wr0), 32'd1);
    check_eq("t4_addr", 32'(wr_addr), 32'h20);
    check_eq("t4_good", 32'(good_cnt), 32'd3);

    // 5: rx_empty lingers low -> one pop per byte
    uld0 = n_uld; wr0 = n_wr;
    send_frame(8'h0A, 8'h0B, 8'h15, 3, 1);
    tick(2);
    check_eq("t5_uld_cnt", 32'(n_uld - uld0), 32'd4);
    check_eq("t5_wr_cnt", 32'(n_wr - wr0), 32'd1);
    check_eq("t5_data", 32'(wr_data), 32'h0B);

    // 6a: reset mid-frame
    chk0 = n_chk; to0 = n_to;
    send_byte(8'hA5, 0, 1);
    send_byte(8'h10, 0, 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_eq("t6_rst_addr", 32'(wr_addr), 32'd0);
    check_eq("t6_rst_good", 32'(good_cnt), 32'd0);
    wr0 = n_wr;
    send_frame(8'h44, 8'h55, 8'h99, 0, 1);
    tick(2);
    check_eq("t6_rst_wr", 32'(n_wr - wr0), 32'd1);
    check_eq("t6_rst_addr2", 32'(wr_addr), 32'h44);
    check_eq("t6_rst_data2", 32'(wr_data), 32'h55);

    // 6b: enable dropped mid-frame
    send_byte(8'hA5, 0, 1);
    send_byte(8'h10, 0, 1);
    enable   = 1'b0;
    rx_data  = 8'h22;
    rx_empty = 1'b0;
    tick(3);
    check_eq("t6_dis_no_pop", 32'(uld_rx_data), 32'd0);
    check_eq("t6_dis_hold_addr", 32'(wr_addr), 32'h44);
    rx_empty = 1'b1;
    tick(2);
    enable = 1'b1;
    tick(1);
    wr0 = n_wr;
    send_byte(8'h22, 0, 1);
    send_byte(8'h32, 0, 1);
    send_frame(8'h66, 8'h77, 8'hDD, 0, 1);
    tick(2);
    check_eq("t6_en_wr", 32'(n_wr - wr0), 32'd1);
    check_eq("t6_en_addr", 32'(wr_addr), 32'h66);
    check_eq("t6_en_good", 32'(good_cnt), 32'd2);
    check_eq("t6_no_err_pulse", 32'((n_chk - chk0) + (n_to - to0)), 32'd0);
    check_eq("t6_bad_zero", 32'(bad_cnt), 32'd0);

    // 6c: bad counter saturation
    for (int i = 0; i < 255; i++) send_frame(8'h01, 8'h01, 8'h00, 0, 0);
    tick(2);
    check_eq("t6_bad_255", 32'(bad_cnt), 32'hFF);
    send_frame(8'h01, 8'h01, 8'h00, 0, 0);
    send_frame(8'h01, 8'h01, 8'h00, 0, 0);
    tick(2);
    check_eq("t6_bad_sat", 32'(bad_cnt), 32'hFF);
    check_eq("t6_chk_pulses", 32'(n_chk - chk0), 32'd257);

    check_eq("excl_pulses", 32'(n_excl), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
